// File: rtl/tinyrv_pkg.sv
// tinyrv_pkg: shared definitions for the tinyrv core.
//   XLEN / ILEN       : datapath and instruction widths (both 16)
//   OP_*              : 3-bit major opcodes, found in instr[15:13]
//   fetch_state_e     : instruction-fetch FSM encoding
//   fetch_entry_t     : one buffered fetch result {pc, instr}
//   RESET_PC_DEFAULT  : default byte address of the first fetch
package tinyrv_pkg;

  localparam int XLEN = 16;
  localparam int ILEN = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    STALL    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [2:0] opcode_of(input logic [ILEN-1:0] i);
    return i[15:13];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry buffer of {pc, instr} entries.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush_i         : drop every entry (wins over push/pop)
//   push_i/push_data_i : write an entry; accepted when not full or popping
//   pop_i           : retire the head entry (ignored when empty)
//   head_o          : head entry, all zeros while empty
//   empty_o/full_o  : occupancy flags
//   almost_full_o   : exactly one free slot left
module fetch_fifo
  import tinyrv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         almost_full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o       = (cnt_q == '0);
  assign full_o        = (cnt_q == CW'(DEPTH));
  assign almost_full_o = (cnt_q == CW'(DEPTH - 1));
  assign do_pop        = pop_i && !empty_o;
  assign do_push       = push_i && (!full_o || do_pop);

  // Gate the head so an empty buffer presents a clean zero word.
  assign head_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= next_ptr(wr_q);
      end
      if (do_pop) rd_q <= next_ptr(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 16-bit big-endian instructions one byte at a time
// from program memory and buffers them for decode.
//   clk, rst_n                 : clock, synchronous active-low reset
//   mem_req/mem_addr           : registered byte-read request
//   mem_ack/mem_rdata          : beat completes on mem_req && mem_ack
//   instr_valid/instr_ready    : decode handshake
//   instr/instr_pc             : FIFO head {instr word, its byte address}
//   redirect_valid/redirect_pc : flush and refetch from a new address
module instr_fetch
  import tinyrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [7:0]      hi_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;

  logic            beat, pop, push, fills;
  logic            fifo_empty, fifo_full, fifo_afull;
  logic [XLEN-1:0] redir_pc, pc_plus1, pc_plus2;
  fetch_entry_t    push_entry, head;

  assign beat     = mem_req_q && mem_ack;
  assign pop      = instr_valid && instr_ready;
  // A low-byte beat racing a redirect belongs to the old stream: drop it.
  assign push     = (state_q == FETCH_LO) && beat && !redirect_valid
                    && (!fifo_full || pop);
  // After this push the buffer is full unless decode frees a slot now.
  assign fills    = fifo_afull && !pop;
  assign redir_pc = {redirect_pc[XLEN-1:1], 1'b0};
  assign pc_plus1 = fetch_pc_q + 16'd1;
  assign pc_plus2 = fetch_pc_q + 16'd2;

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = {hi_q, mem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (redirect_valid),
    .push_i        (push),
    .push_data_i   (push_entry),
    .pop_i         (pop),
    .head_o        (head),
    .empty_o       (fifo_empty),
    .full_o        (fifo_full),
    .almost_full_o (fifo_afull)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_HI;
      fetch_pc_q <= RESET_PC;
      hi_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else if (redirect_valid) begin
      state_q    <= FETCH_HI;
      fetch_pc_q <= redir_pc;
      hi_q       <= '0;
      mem_req_q  <= 1'b1;
      mem_addr_q <= redir_pc;
    end else begin
      case (state_q)
        FETCH_HI: begin
          // Request is low only right after reset; address already set.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (beat) begin
            hi_q       <= mem_rdata;
            state_q    <= FETCH_LO;
            mem_addr_q <= pc_plus1;
          end
        end
        FETCH_LO: begin
          if (beat) begin
            fetch_pc_q <= pc_plus2;
            mem_addr_q <= pc_plus2;
            if (fills) begin
              state_q   <= STALL;
              mem_req_q <= 1'b0;
            end else begin
              state_q   <= FETCH_HI;
            end
          end
        end
        STALL: begin
          if (pop) begin
            state_q   <= FETCH_HI;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= FETCH_HI;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n, rst_b_n;

  // Instance A: default parameters, memory with programmable wait states.
  logic        req_a, ack_a, val_a, rdy_a, redir_a;
  logic [15:0] addr_a, ins_a, ipc_a, rpc_a;
  logic [7:0]  rdata_a;
  int          waits_a, wcnt_a;

  // Instance B: RESET_PC=FFFE, 3-deep buffer, memory acks every request.
  logic        req_b, ack_b, val_b, rdy_b, redir_b;
  logic [15:0] addr_b, ins_b, ipc_b, rpc_b;
  logic [7:0]  rdata_b;

  logic [31:0] qa[$], qb[$];
  int          n_chk, n_err;

  instr_fetch u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_req(req_a), .mem_addr(addr_a), .mem_ack(ack_a), .mem_rdata(rdata_a),
    .instr_valid(val_a), .instr_ready(rdy_a), .instr(ins_a), .instr_pc(ipc_a),
    .redirect_valid(redir_a), .redirect_pc(rpc_a)
  );

  instr_fetch #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_b), .mem_rdata(rdata_b),
    .instr_valid(val_b), .instr_ready(rdy_b), .instr(ins_b), .instr_pc(ipc_b),
    .redirect_valid(redir_b), .redirect_pc(rpc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Even byte {A, a[4:1]}, odd byte {0, a[4:1]}+1: pc 0000 -> A001.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[0] ? ({4'h0, a[4:1]} + 8'h01) : {4'hA, a[4:1]};
  endfunction

  assign rdata_a = mem_byte(addr_a);
  assign rdata_b = mem_byte(addr_b);
  assign ack_a   = req_a && (wcnt_a >= waits_a);
  assign ack_b   = req_b;

  always @(posedge clk) begin
    if (!rst_n || !req_a || ack_a) wcnt_a <= 0;
    else                           wcnt_a <= wcnt_a + 1;
  end

  // Log every accepted instruction as {pc, instr}.
  always @(posedge clk) begin
    if (rst_n && val_a && rdy_a)   qa.push_back({ipc_a, ins_a});
    if (rst_b_n && val_b && rdy_b) qb.push_back({ipc_b, ins_b});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qa_at(input int i);
    return (i < qa.size()) ? qa[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] qb_at(input int i);
    return (i < qb.size()) ? qb[i] : 32'hDEAD_DEAD;
  endfunction

  logic [31:0] exp_seq [4];
  logic        p_pend;
  logic [15:0] p_addr;

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; rst_b_n = 1'b0;
    rdy_a = 1'b1; redir_a = 1'b0; rpc_a = '0; waits_a = 0;
    rdy_b = 1'b0; redir_b = 1'b0; rpc_b = '0;
    exp_seq[0] = {16'h0000, 16'hA001};
    exp_seq[1] = {16'h0002, 16'hA102};
    exp_seq[2] = {16'h0004, 16'hA203};
    exp_seq[3] = {16'h0006, 16'hA304};

    // ---- reset values and streaming with ack every cycle
    repeat (3) tick();
    chk("rst_req", req_a, 1'b0);
    chk("rst_addr", addr_a, 16'h0000);
    chk("rst_valid", val_a, 1'b0);
    chk("rst_instr", ins_a, 16'h0000);
    chk("rst_pc", ipc_a, 16'h0000);
    qa.delete();
    rst_n = 1'b1;
    tick();
    chk("rel_req", req_a, 1'b1);
    chk("rel_addr", addr_a, 16'h0000);
    tick();
    chk("c2_valid", val_a, 1'b0);
    chk("c2_addr", addr_a, 16'h0001);
    tick();
    chk("c3_valid", val_a, 1'b1);
    chk("c3_pc", ipc_a, 16'h0000);
    chk("c3_instr", ins_a, 16'hA001);
    repeat (6) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("stream%0d", i), qa_at(i), exp_seq[i]);

    // ---- backpressure: two entries buffered, then STALL
    rst_n = 1'b0; rdy_a = 1'b0;
    repeat (2) tick();
    qa.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("stall_req", req_a, 1'b0);
    chk("stall_valid", val_a, 1'b1);
    chk("stall_pc", ipc_a, 16'h0000);
    chk("stall_instr", ins_a, 16'hA001);
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    chk("unstall_req", req_a, 1'b1);
    chk("unstall_addr", addr_a, 16'h0004);
    chk("unstall_head", ipc_a, 16'h0002);
    rdy_a = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("bp_seq%0d", i), qa_at(i), exp_seq[i]);

    // ---- three wait cycles per byte
    rst_n = 1'b0; waits_a = 3;
    repeat (2) tick();
    qa.delete();
    rst_n = 1'b1;
    p_pend = 1'b0; p_addr = '0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (p_pend && req_a) chk("addr_hold", addr_a, p_addr);
      p_pend = req_a && !ack_a;
      p_addr = addr_a;
    end
    waits_a = 0;
    for (int i = 0; i < 4; i++) chk($sformatf("wait_seq%0d", i), qa_at(i), exp_seq[i]);

    // ---- reset between hi and lo beats
    rst_n = 1'b0;
    repeat (2) tick();
    qa.delete();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_addr_lo", addr_a, 16'h0001);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req", req_a, 1'b0);
    chk("mid_rst_valid", val_a, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_addr", addr_a, 16'h0000);
    tick();
    tick();
    chk("mid_first", {ipc_a, ins_a}, {16'h0000, 16'hA001});
    chk("mid_no_partial", qa.size(), 0);

    // ---- back-to-back redirects with a same-cycle handshake
    redir_a = 1'b1; rpc_a = 16'h0040;
    tick();
    rpc_a = 16'h0087;
    tick();
    redir_a = 1'b0;
    chk("redir_valid", val_a, 1'b0);
    chk("redir_req", req_a, 1'b1);
    chk("redir_addr", addr_a, 16'h0086);
    repeat (4) tick();
    chk("redir_hs", qa_at(0), {16'h0000, 16'hA001});
    chk("redir_first", qa_at(1), {16'h0086, 16'hA304});

    // ---- instance B: wrap at FFFE and redirect during a low-byte ack
    rst_b_n = 1'b0;
    repeat (2) tick();
    chk("b_rst_req", req_b, 1'b0);
    chk("b_rst_addr", addr_b, 16'hFFFE);
    qb.delete();
    rst_b_n = 1'b1;
    tick();
    chk("b_rel_addr", addr_b, 16'hFFFE);
    tick();
    chk("b_lo_addr", addr_b, 16'hFFFF);
    tick();
    chk("b_first", {ipc_b, ins_b}, {16'hFFFE, 16'hAF10});
    tick();
    rdy_b = 1'b1;
    tick();
    rdy_b = 1'b0;
    chk("b_wrap", {ipc_b, ins_b}, {16'h0000, 16'hA001});
    repeat (3) tick();
    chk("b_pre_redir_addr", addr_b, 16'h0005);
    redir_b = 1'b1; rpc_b = 16'h1235;
    tick();
    redir_b = 1'b0;
    chk("b_redir_valid", val_b, 1'b0);
    chk("b_redir_req", req_b, 1'b1);
    chk("b_redir_addr", addr_b, 16'h1234);
    rdy_b = 1'b1;
    repeat (6) tick();
    chk("b_seq0", qb_at(0), {16'hFFFE, 16'hAF10});
    chk("b_seq1", qb_at(1), {16'h1234, 16'hAA0B});
    chk("b_seq2", qb_at(2), {16'h1236, 16'hAB0C});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
